// File: rtl/coin_input_conditioner.sv
// Parking meter switch front end: sync, debounce, coin edge capture.
// Coin edges queue in pending and drain one per cycle, lowest index first.
module coin_input_conditioner #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int COIN0_SEC = 5,
  parameter int COIN1_SEC = 10,
  parameter int COIN2_SEC = 25
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] sw_coin,
  input  logic       sw_start,
  output logic       coin_valid,
  output logic [7:0] coin_sec,
  output logic [1:0] coin_id,
  output logic       start_level,
  output logic [2:0] pending
);

  localparam int CW =
    (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CMAX = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [7:0] SEC0 = 8'(COIN0_SEC);
  localparam logic [7:0] SEC1 = 8'(COIN1_SEC);
  localparam logic [7:0] SEC2 = 8'(COIN2_SEC);

  if (DEBOUNCE_CYCLES < 2 || DEBOUNCE_CYCLES > (1 << 20)) begin : g_bad_db
    $error("DEBOUNCE_CYCLES out of range 2..2^20");
  end
  if (COIN0_SEC < 0 || COIN0_SEC > 255 ||
      COIN1_SEC < 0 || COIN1_SEC > 255 ||
      COIN2_SEC < 0 || COIN2_SEC > 255) begin : g_bad_sec
    $error("coin seconds must fit in 8 bits");
  end

  logic [3:0]    raw;
  logic [3:0]    s1;
  logic [3:0]    s2;
  logic [3:0]    stable;
  logic [CW-1:0] cnt [4];
  logic [2:0]    rise;
  logic [2:0]    clr;
  logic          pick;
  logic [1:0]    pick_id;
  logic [7:0]    pick_sec;

  assign raw = {sw_start, sw_coin};
  assign start_level = stable[3];

  // two-flop synchroniser on all four switch channels
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= raw;
      s2 <= s1;
    end
  end

  // per-channel stability counter; level follows after a full stable run
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stable <= '0;
      for (int i = 0; i < 4; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (s2[i] == stable[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CMAX) begin
          stable[i] <= s2[i];
          cnt[i]    <= '0;
        end else begin
          cnt[i] <= cnt[i] + CW'(1);
        end
      end
    end
  end

  // a coin edge is the cycle its debounced level flips from 0 to 1
  always_comb begin
    rise = '0;
    for (int i = 0; i < 3; i++) begin
      rise[i] = s2[i] && !stable[i] && (cnt[i] == CMAX);
    end
  end

  // lowest pending index wins the emitter this cycle
  always_comb begin
    pick     = 1'b0;
    pick_id  = 2'd0;
    pick_sec = 8'd0;
    clr      = 3'b000;
    if (pending[0]) begin
      pick     = 1'b1;
      pick_id  = 2'd0;
      pick_sec = SEC0;
      clr      = 3'b001;
    end else if (pending[1]) begin
      pick     = 1'b1;
      pick_id  = 2'd1;
      pick_sec = SEC1;
      clr      = 3'b010;
    end else if (pending[2]) begin
      pick     = 1'b1;
      pick_id  = 2'd2;
      pick_sec = SEC2;
      clr      = 3'b100;
    end
  end

  // pending queue (new edge beats clear) and registered event outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pending    <= '0;
      coin_valid <= 1'b0;
      coin_id    <= 2'd0;
      coin_sec   <= 8'd0;
    end else begin
      pending    <= (pending & ~clr) | rise;
      coin_valid <= pick;
      coin_id    <= pick_id;
      coin_sec   <= pick_sec;
    end
  end

endmodule

// File: tb/tb_coin_input_conditioner.sv
// Directed bench for coin_input_conditioner with DEBOUNCE_CYCLES=4.
// Vector table for the simultaneous press, hand sequences for the rest.
module tb_coin_input_conditioner;

  logic       clk;
  logic       reset;
  logic [2:0] sw_coin;
  logic       sw_start;
  logic       coin_valid;
  logic [7:0] coin_sec;
  logic [1:0] coin_id;
  logic       start_level;
  logic [2:0] pending;

  int n_chk;
  int n_err;
  int ev [3];
  int ev_total;
  int idle_bad;
  int sec_bad;
  logic [7:0] last_sec;

  coin_input_conditioner #(
    .DEBOUNCE_CYCLES(4),
    .COIN0_SEC(5),
    .COIN1_SEC(10),
    .COIN2_SEC(25)
  ) dut (
    .clk(clk),
    .reset(reset),
    .sw_coin(sw_coin),
    .sw_start(sw_start),
    .coin_valid(coin_valid),
    .coin_sec(coin_sec),
    .coin_id(coin_id),
    .start_level(start_level),
    .pending(pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] sec_of(input logic [1:0] id);
    case (id)
      2'd0: return 8'd5;
      2'd1: return 8'd10;
      2'd2: return 8'd25;
      default: return 8'd0;
    endcase
  endfunction

  // event monitor, sampled on the falling edge
  always @(negedge clk) begin
    if (coin_valid) begin
      if (coin_id <= 2'd2) ev[coin_id] = ev[coin_id] + 1;
      ev_total = ev_total + 1;
      last_sec = coin_sec;
      if (coin_sec != sec_of(coin_id)) sec_bad = sec_bad + 1;
    end else if (coin_sec != 8'd0 || coin_id != 2'd0) begin
      idle_bad = idle_bad + 1;
    end
  end

  task automatic chk(input string name, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk = n_chk + 1;
    if (got !== exp) begin
      n_err = n_err + 1;
      $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [2:0] coin;
    logic       start;
    logic       valid;
    logic [1:0] id;
    logic [7:0] sec;
    logic [2:0] pend;
    logic       st;
  } vec_t;

  vec_t tv [10];

  initial begin
    int snap [3];
    int snap_t;
    int bad;
    n_chk = 0;
    n_err = 0;
    ev_total = 0;
    idle_bad = 0;
    sec_bad = 0;
    last_sec = 8'd0;
    for (int i = 0; i < 3; i++) ev[i] = 0;

    tv[0] = '{3'b111, 1'b1, 1'b0, 2'd0, 8'd0,  3'b000, 1'b0};
    tv[1] = '{3'b111, 1'b1, 1'b0, 2'd0, 8'd0,  3'b000, 1'b0};
    tv[2] = '{3'b111, 1'b1, 1'b0, 2'd0, 8'd0,  3'b000, 1'b0};
    tv[3] = '{3'b111, 1'b1, 1'b0, 2'd0, 8'd0,  3'b000, 1'b0};
    tv[4] = '{3'b111, 1'b1, 1'b0, 2'd0, 8'd0,  3'b000, 1'b0};
    tv[5] = '{3'b111, 1'b1, 1'b0, 2'd0, 8'd0,  3'b111, 1'b1};
    tv[6] = '{3'b111, 1'b1, 1'b1, 2'd0, 8'd5,  3'b110, 1'b1};
    tv[7] = '{3'b111, 1'b1, 1'b1, 2'd1, 8'd10, 3'b100, 1'b1};
    tv[8] = '{3'b111, 1'b1, 1'b1, 2'd2, 8'd25, 3'b000, 1'b1};
    tv[9] = '{3'b111, 1'b1, 1'b0, 2'd0, 8'd0,  3'b000, 1'b1};

    reset = 1'b0;
    sw_coin = 3'b000;
    sw_start = 1'b0;
    step();
    step();
    chk("reset_valid", 32'(coin_valid), 32'd0);
    chk("reset_sec", 32'(coin_sec), 32'd0);
    chk("reset_id", 32'(coin_id), 32'd0);
    chk("reset_start", 32'(start_level), 32'd0);
    chk("reset_pending", 32'(pending), 32'd0);

    reset = 1'b1;
    step();
    chk("first_after_release", 32'(coin_valid), 32'd0);

    repeat (1000) step();
    chk("idle_events", 32'(ev_total), 32'd0);
    chk("idle_outputs", 32'(idle_bad), 32'd0);

    for (int i = 0; i < 10; i++) begin
      sw_coin = tv[i].coin;
      sw_start = tv[i].start;
      step();
      chk($sformatf("simul_v%0d", i),
          32'({coin_valid, coin_id, coin_sec, pending, start_level}),
          32'({tv[i].valid, tv[i].id, tv[i].sec, tv[i].pend, tv[i].st}));
    end

    snap_t = ev_total;
    sw_coin = 3'b000;
    repeat (12) step();
    chk("falling_no_event", 32'(ev_total - snap_t), 32'd0);

    sw_start = 1'b0;
    step();
    step();
    sw_start = 1'b1;
    bad = 0;
    for (int k = 0; k < 15; k++) begin
      step();
      if (start_level !== 1'b1) bad = bad + 1;
    end
    chk("start_glitch_held", 32'(bad), 32'd0);

    sw_coin = 3'b010;
    for (int k = 1; k <= 9; k++) begin
      step();
      chk($sformatf("press1_c%0d", k),
          32'({coin_valid, coin_id, coin_sec}),
          (k == 7) ? 32'({1'b1, 2'd1, 8'd10}) : 32'd0);
    end
    sw_coin = 3'b000;
    repeat (12) step();
    snap[1] = ev[1];
    sw_coin = 3'b010;
    repeat (12) step();
    chk("press2_count", 32'(ev[1] - snap[1]), 32'd1);
    chk("press2_sec", 32'(last_sec), 32'd10);
    sw_coin = 3'b000;
    repeat (12) step();

    snap_t = ev_total;
    snap[0] = ev[0];
    for (int k = 0; k < 20; k++) begin
      sw_coin[0] = ((k / 2) % 2 == 0) ? 1'b1 : 1'b0;
      step();
    end
    sw_coin[0] = 1'b1;
    repeat (20) step();
    chk("bounce_count", 32'(ev_total - snap_t), 32'd1);
    chk("bounce_coin0", 32'(ev[0] - snap[0]), 32'd1);
    chk("bounce_sec", 32'(last_sec), 32'd5);

    sw_coin = 3'b000;
    repeat (12) step();
    snap_t = ev_total;
    sw_coin[0] = 1'b1;
    repeat (3) step();
    sw_coin[0] = 1'b0;
    repeat (20) step();
    chk("glitch3_none", 32'(ev_total - snap_t), 32'd0);

    sw_coin = 3'b111;
    repeat (6) step();
    chk("mid_pending", 32'(pending), 32'd7);
    #2;
    reset = 1'b0;
    #1;
    chk("async_reset_out",
        32'({coin_valid, coin_id, coin_sec, pending, start_level}),
        32'd0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    snap_t = ev_total;
    for (int i = 0; i < 3; i++) snap[i] = ev[i];
    step();
    chk("post_reset_first", 32'(coin_valid), 32'd0);
    repeat (20) step();
    chk("post_reset_total", 32'(ev_total - snap_t), 32'd3);
    chk("post_reset_ids",
        32'({8'(ev[0] - snap[0]), 8'(ev[1] - snap[1]),
             8'(ev[2] - snap[2])}),
        32'({8'd1, 8'd1, 8'd1}));

    chk("sec_matches_id", 32'(sec_bad), 32'd0);
    chk("idle_clean", 32'(idle_bad), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
